// File: rtl/envelope_adsr_if.sv
// Audio/control bundle between the envelope and its sample source/sink.
// The DUT takes the slave modport; the driver (sequencer or bench) takes master.
interface envelope_adsr_if #(
   parameter int unsigned BITSIZE  = 24,
   parameter int unsigned ENVSIZE  = 16,
   parameter int unsigned RATESIZE = 16
);
   logic                lrclk;
   logic                gate;
   logic [RATESIZE-1:0] attack;
   logic [RATESIZE-1:0] decay;
   logic [RATESIZE-1:0] release_rate;
   logic [ENVSIZE-1:0]  sustain;
   logic [BITSIZE-1:0]  sample_in;
   logic [BITSIZE-1:0]  sample_out;
   logic [ENVSIZE-1:0]  level;
   logic                active;

   modport slave (
      input  lrclk, gate, attack, decay, release_rate, sustain, sample_in,
      output sample_out, level, active
   );

   modport master (
      output lrclk, gate, attack, decay, release_rate, sustain, sample_in,
      input  sample_out, level, active
   );
endinterface

// File: rtl/envelope_adsr.sv
// ADSR amplitude envelope: one level step per lrclk frame, out = in * level >>> ENVSIZE.
// Optional macro ENVELOPE_EXP_RELEASE_EN selects an exponential release tail.
module envelope_adsr #(
   parameter int unsigned BITSIZE  = 24,
   parameter int unsigned ENVSIZE  = 16,
   parameter int unsigned RATESIZE = 16
) (
   input  logic clk,
   input  logic rst_n,
   envelope_adsr_if.slave bus
);
   localparam int unsigned PRODW = BITSIZE + ENVSIZE + 1;
   localparam int unsigned SUMW  = ((RATESIZE > ENVSIZE) ? RATESIZE : ENVSIZE) + 1;
   localparam logic [ENVSIZE-1:0] FULL = '1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ATTACK,
      S_DECAY,
      S_SUSTAIN,
      S_RELEASE
   } state_e;

   logic                      lr_meta_q, lr_sync_q, lr_prev_q;
   logic                      strobe_c;
   state_e                    state_q, state_d, stage_c;
   logic [ENVSIZE-1:0]        level_q, level_d;
   logic                      gate_q, gate_d;
   logic [BITSIZE-1:0]        out_q, out_d;
   logic                      active_q, active_d;
   logic signed [PRODW-1:0]   prod_c;
   logic [SUMW-1:0]           level_ext_c, att_sum_c, dec_sub_c, dec_diff_c;
   logic [SUMW-1:0]           sus_ext_c, rel_step_c;

   // lrclk synchronizer and rising-edge detector
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lr_meta_q <= 1'b0;
         lr_sync_q <= 1'b0;
         lr_prev_q <= 1'b0;
      end else begin
         lr_meta_q <= bus.lrclk;
         lr_sync_q <= lr_meta_q;
         lr_prev_q <= lr_sync_q;
      end
   end

   assign strobe_c = lr_sync_q & ~lr_prev_q;

   // level is zero-extended so the multiply treats it as a positive gain
   assign prod_c = PRODW'($signed(bus.sample_in)) * PRODW'($signed({1'b0, level_q}));

   assign level_ext_c = SUMW'(level_q);
   assign sus_ext_c   = SUMW'(bus.sustain);
   assign att_sum_c   = level_ext_c + SUMW'(bus.attack);
   assign dec_sub_c   = SUMW'(bus.decay);
   assign dec_diff_c  = level_ext_c - dec_sub_c;

`ifdef ENVELOPE_EXP_RELEASE_EN
   localparam int unsigned MULW = ENVSIZE + RATESIZE;
   logic [MULW-1:0] rel_mul_c;
   assign rel_mul_c  = MULW'(level_q) * MULW'(bus.release_rate);
   // the +1 keeps the tail from stalling above zero
   assign rel_step_c = SUMW'(rel_mul_c >> ENVSIZE) + SUMW'(1);
`else
   assign rel_step_c = SUMW'(bus.release_rate);
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         level_q  <= '0;
         gate_q   <= 1'b0;
         out_q    <= '0;
         active_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         level_q  <= level_d;
         gate_q   <= gate_d;
         out_q    <= out_d;
         active_q <= active_d;
      end
   end

   // Stage selection by gate priority, then that stage's level rule, all on strobe
   always_comb begin
      state_d = state_q;
      level_d = level_q;
      gate_d  = gate_q;
      out_d   = out_q;
      stage_c = state_q;
      if (strobe_c) begin
         gate_d = bus.gate;
         out_d  = BITSIZE'(prod_c >>> ENVSIZE);
         if (bus.gate && !gate_q) begin
            stage_c = S_ATTACK;
         end else if (!bus.gate && (state_q == S_ATTACK || state_q == S_DECAY ||
                                    state_q == S_SUSTAIN)) begin
            stage_c = S_RELEASE;
         end
         state_d = stage_c;
         unique case (stage_c)
            S_IDLE: begin
               level_d = '0;
            end
            S_ATTACK: begin
               if (bus.attack == '0 || att_sum_c >= SUMW'(FULL)) begin
                  level_d = FULL;
                  state_d = S_DECAY;
               end else begin
                  level_d = ENVSIZE'(att_sum_c);
               end
            end
            S_DECAY: begin
               if (bus.decay == '0 || dec_sub_c > level_ext_c || dec_diff_c <= sus_ext_c) begin
                  level_d = bus.sustain;
                  state_d = S_SUSTAIN;
               end else begin
                  level_d = ENVSIZE'(dec_diff_c);
               end
            end
            S_SUSTAIN: begin
               level_d = bus.sustain;
            end
            S_RELEASE: begin
               if (bus.release_rate == '0 || rel_step_c >= level_ext_c) begin
                  level_d = '0;
                  state_d = S_IDLE;
               end else begin
                  level_d = ENVSIZE'(level_ext_c - rel_step_c);
               end
            end
            default: begin
               level_d = '0;
               state_d = S_IDLE;
            end
         endcase
      end
      active_d = (state_d != S_IDLE);
   end

   assign bus.sample_out = out_q;
   assign bus.level      = level_q;
   assign bus.active     = active_q;
endmodule
